// File: rtl/adder_sub_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_sub_if : operand/result bundle for the registered adder/subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
interface adder_sub_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             control;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, control,
        input  out, cout, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, control,
        output out, cout, ovf, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/adder_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_sub : ripple-carry two's-complement add/subtract, registered outputs
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_sub #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    adder_sub_if.slave    bus
);
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    // control doubles as carry-in so subtract becomes a + ~b + 1
    assign w_carry[0] = bus.control;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign w_bx[i]      = bus.b[i] ^ bus.control;
            assign w_sum[i]     = bus.a[i] ^ w_bx[i] ^ w_carry[i];
            assign w_carry[i+1] = (bus.a[i] & w_bx[i]) |
                                  (bus.a[i] & w_carry[i]) |
                                  (w_bx[i]  & w_carry[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out  <= w_sum;
                r_cout <= w_carry[WIDTH];
                r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_adder_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adder_sub : directed and exhaustive checks for adder_sub (WIDTH = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_adder_sub;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_sub_if #(.WIDTH(WIDTH)) bus ();

    adder_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the capturing edge.
    task automatic apply(input logic rst, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic ctl);
        @(negedge clk);
        rst_n        = rst;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.control  = ctl;
        @(posedge clk);
        #1;
    endtask

    // Result packed as {out, cout, ovf, out_valid}.
    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.out, bus.cout, bus.ovf, bus.out_valid};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={out,cout,ovf,vld}=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model(input logic ctl, input logic [3:0] a,
                                         input logic [3:0] b);
        int ua, ub, sa, sb, ru, rs;
        logic [3:0] o;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ru = ctl ? (ua - ub) : (ua + ub);
        rs = ctl ? (sa - sb) : (sa + sb);
        o  = ru[3:0];
        c  = ctl ? (ua >= ub) : (ru > 15);
        v  = (rs > 7) || (rs < -8);
        return {o, c, v, 1'b1};
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.control  = 1'b0;

        // Reset with live operands on the bus
        apply(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
        check("reset_c1", 7'b0000_0_0_0);
        apply(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
        check("reset_c2", 7'b0000_0_0_0);

        // Add
        apply(1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0);
        check("add_0_4", 7'b0100_0_0_1);
        apply(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        check("add_1_1", 7'b0010_0_0_1);
        apply(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check("add_0_0", 7'b0000_0_0_1);
        apply(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
        check("add_wrap", 7'b0000_1_0_1);

        // Subtract, no borrow
        apply(1'b1, 1'b1, 4'b1111, 4'b0101, 1'b1);
        check("sub_f_5", 7'b1010_1_0_1);
        apply(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        check("sub_equal", 7'b0000_1_0_1);

        // Borrow and signed overflow
        apply(1'b1, 1'b1, 4'b0001, 4'b0010, 1'b1);
        check("sub_borrow", 7'b1111_0_0_1);
        apply(1'b1, 1'b1, 4'b0111, 4'b0001, 1'b0);
        check("add_ovf", 7'b1000_0_1_1);
        apply(1'b1, 1'b1, 4'b1000, 4'b0001, 1'b1);
        check("sub_ovf", 7'b0111_1_1_1);

        // Single valid then idle with changing operands: value holds, valid drops
        apply(1'b1, 1'b1, 4'b0011, 4'b0100, 1'b0);
        check("hold_load", 7'b0111_0_0_1);
        apply(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0);
        check("hold_idle1", 7'b0111_0_0_0);
        apply(1'b1, 1'b0, 4'b1000, 4'b0111, 1'b1);
        check("hold_idle2", 7'b0111_0_0_0);
        apply(1'b1, 1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        check("hold_idle_x", 7'b0111_0_0_0);

        // Exhaustive back-to-back stream
        for (int ctl = 0; ctl < 2; ctl++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    apply(1'b1, 1'b1, 4'(ia), 4'(ib), 1'(ctl));
                    check($sformatf("exh_c%0d_a%0d_b%0d", ctl, ia, ib),
                          model(1'(ctl), 4'(ia), 4'(ib)));
                end
            end
        end

        // Mid-stream reset discards the in-flight result
        apply(1'b1, 1'b1, 4'b0110, 4'b0111, 1'b0);
        check("pre_rst", 7'b1101_0_1_1);
        apply(1'b0, 1'b1, 4'b1001, 4'b0011, 1'b1);
        check("mid_rst", 7'b0000_0_0_0);
        apply(1'b1, 1'b1, 4'b1001, 4'b0011, 1'b1);
        check("post_rst", 7'b0110_1_1_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_sub.md
Name: adder_sub

Overview:
- Parameterised two's-complement adder/subtractor built as a ripple-carry chain of full adders.
- Input b is conditionally inverted by the mode control, and control is also the carry-in.
- Results are registered: one clock of latency, synchronous active-low reset.
- Used as the arithmetic primitive in small datapaths that need add and subtract from one adder.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low; sampled on rising edge of clk.
- in_valid  input  1  operands/control valid this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- control  input  1  mode: 0 = add (a+b), 1 = subtract (a-b).
- out  output  WIDTH  registered result, low WIDTH bits.
- cout  output  1  registered carry-out of MSB full adder.
- ovf  output  1  registered signed overflow flag.
- out_valid  output  1  registered; high when out/cout/ovf hold a new result.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Datapath (combinational, before the output register):
  - bx[i] = b[i] XOR control, for each bit i.
  - c[0] = control.
  - Each stage i is a full adder: s[i] = a[i]^bx[i]^c[i]; c[i+1] = majority(a[i], bx[i], c[i]).
  - cout_next = c[WIDTH]; ovf_next = c[WIDTH] XOR c[WIDTH-1].
- Add (control=0):
  - out = (a+b) mod 2^WIDTH.
  - cout = 1 on unsigned overflow.
- Subtract (control=1):
  - out = (a-b) mod 2^WIDTH, computed as a + ~b + 1.
  - cout = 1 means no borrow (a >= b unsigned); cout = 0 means borrow (a < b).
- ovf = 1 when the signed two's-complement result is not representable in WIDTH bits, in either mode.
- Timing:
  - On rising clk with rst_n=1 and in_valid=1: out, cout, ovf capture the *_next values; out_valid <= 1.
  - With rst_n=1 and in_valid=0: out, cout, ovf hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back inputs every cycle are accepted. No backpressure.
- Reset:
  - Rising clk with rst_n=0: out <= 0, cout <= 0, ovf <= 0, out_valid <= 0, regardless of in_valid.
  - Reset asserted mid-stream discards any in-flight result.
  - First valid output appears 1 cycle after the first in_valid sampled with rst_n=1.
- No internal state beyond the output registers; no latches; no X propagation from an idle input when in_valid=0.
- Boundary: subtracting equal operands gives out=0, cout=1. a=0,b=0 add gives out=0, cout=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and a=4'b1111, b=4'b1111 -> out=0000, cout=0, ovf=0, out_valid=0.
- Add: a=0000, b=0100, control=0, in_valid=1 -> next cycle out=0100, cout=0, ovf=0, out_valid=1. Then a=0001, b=0001 -> out=0010, cout=0.
- Subtract no borrow: a=1111, b=0101, control=1 -> out=1010, cout=1, ovf=0. Then a=1111, b=1111 -> out=0000, cout=1, ovf=0.
- Borrow and overflow:
  - a=0001, b=0010, control=1 -> out=1111, cout=0, ovf=0.
  - a=0111, b=0001, control=0 -> out=1000, cout=0, ovf=1.
  - a=1000, b=0001, control=1 -> out=0111, cout=1, ovf=1.
- Valid/hold: in_valid=1 for one cycle (a=0011, b=0100, add) then in_valid=0 with changing a/b -> out stays 0111, out_valid pulses high for exactly one cycle.
- Exhaustive: all 2×16×16 combinations streamed back-to-back with in_valid=1 -> each result matches the reference model one cycle later; mid-stream rst_n=0 clears outputs on the next edge.
